// File: rtl/load_store_multi.sv
// load_store_multi: NCH independent triangle/sawtooth level ramps between LO and HI.
// Each channel steps its level by STEP with saturation at both bounds, flags when
// it sits at HI, and pulses wrap when a sawtooth ramp reloads from HI to LO.
// Optional build macro LOAD_STORE_DWELL_EN adds a per-channel dwell counter that
// holds the level at HI for DWELL extra cycles before turning down or reloading.
module load_store_multi #(
  parameter int NCH   = 4,
  parameter int CBITS = 18,
  parameter int LO    = 0,
  parameter int HI    = 200000,
  parameter int STEP  = 1,
  parameter int DWELL = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         en,
  input  logic [NCH-1:0]         clr,
  input  logic [NCH-1:0]         saw,
  output logic [NCH*CBITS-1:0]   vol,
  output logic [NCH-1:0]         sig,
  output logic [NCH-1:0]         dir,
  output logic [NCH-1:0]         wrap
);

  typedef enum logic {DN = 1'b0, UP = 1'b1} dir_t;

  // Bounds and step in level width and in the one-bit-wider saturation width
  localparam logic [CBITS-1:0] LO_C   = CBITS'(LO);
  localparam logic [CBITS-1:0] HI_C   = CBITS'(HI);
  localparam logic [CBITS-1:0] STEP_C = CBITS'(STEP);
  localparam logic [CBITS:0]   LO_X   = (CBITS+1)'(LO);
  localparam logic [CBITS:0]   HI_X   = (CBITS+1)'(HI);
  localparam logic [CBITS:0]   STEP_X = (CBITS+1)'(STEP);

`ifdef LOAD_STORE_DWELL_EN
  localparam int DBITS = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
  localparam logic [DBITS-1:0] DWELL_C = DBITS'(DWELL);
`endif

  genvar g;
  for (g = 0; g < NCH; g++) begin : g_ch
    logic [CBITS-1:0] lvl;
    logic [CBITS-1:0] lvl_nxt;
    dir_t             m;
    dir_t             m_nxt;
    logic             sig_q;
    logic             wrap_q;
    logic             wrap_nxt;
    logic [CBITS:0]   lvl_x;
    logic [CBITS:0]   up_x;
    logic [CBITS-1:0] up_sat;
    logic [CBITS-1:0] dn_sat;
    logic             at_hi;
    logic             at_lo;
    logic             dwell_hold;

`ifdef LOAD_STORE_DWELL_EN
    logic [DBITS-1:0] dcnt;
    logic [DBITS-1:0] dcnt_nxt;

    assign dwell_hold = (dcnt < DWELL_C);
`else
    // Without the dwell option the hold term is constant false and DWELL has no effect
    assign dwell_hold = (DWELL < 0);
`endif

    // Saturating up/down steps, computed one bit wider so they cannot wrap past a bound
    always_comb begin
      lvl_x  = {1'b0, lvl};
      up_x   = lvl_x + STEP_X;
      up_sat = (up_x >= HI_X) ? HI_C : up_x[CBITS-1:0];
      dn_sat = (lvl_x <= LO_X + STEP_X) ? LO_C : (lvl - STEP_C);
      at_hi  = (lvl >= HI_C);
      at_lo  = (lvl <= LO_C);
    end

    // Next-state selection: clear wins over hold, hold wins over the ramp update
    always_comb begin
      lvl_nxt  = lvl;
      m_nxt    = m;
      wrap_nxt = 1'b0;
`ifdef LOAD_STORE_DWELL_EN
      dcnt_nxt = dcnt;
`endif
      if (clr[g]) begin
        lvl_nxt = LO_C;
        m_nxt   = DN;
`ifdef LOAD_STORE_DWELL_EN
        dcnt_nxt = '0;
`endif
      end else if (en[g]) begin
        if (m == UP) begin
          if (at_hi) begin
            if (dwell_hold) begin
`ifdef LOAD_STORE_DWELL_EN
              dcnt_nxt = dcnt + 1'b1;
`endif
            end else begin
`ifdef LOAD_STORE_DWELL_EN
              dcnt_nxt = '0;
`endif
              if (saw[g]) begin
                lvl_nxt  = LO_C;
                wrap_nxt = 1'b1;
              end else begin
                m_nxt = DN;
              end
            end
          end else begin
            lvl_nxt = up_sat;
          end
        end else begin
          if (saw[g] || at_lo) begin
            m_nxt = UP;
          end else begin
            lvl_nxt = dn_sat;
          end
        end
      end
    end

    // Channel state and registered flags; sig describes the level being loaded
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lvl    <= LO_C;
        m      <= DN;
        sig_q  <= 1'b0;
        wrap_q <= 1'b0;
`ifdef LOAD_STORE_DWELL_EN
        dcnt   <= '0;
`endif
      end else begin
        lvl    <= lvl_nxt;
        m      <= m_nxt;
        sig_q  <= (lvl_nxt == HI_C);
        wrap_q <= wrap_nxt;
`ifdef LOAD_STORE_DWELL_EN
        dcnt   <= dcnt_nxt;
`endif
      end
    end

    assign vol[g*CBITS +: CBITS] = lvl;
    assign sig[g]  = sig_q;
    assign dir[g]  = (m == UP);
    assign wrap[g] = wrap_q;
  end

endmodule
